dds_phase_ctrl: RTL and testbench



---
 rtl/dds_phase_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dds_phase_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_ctrl.sv
// ---------------------------------------------------------------------------
// dds_phase_ctrl
//
// Turns keypad waveform/frequency settings into a DDS phase stream. The
// settings are registered and compared with the previous sample. Any change
// starts a two-stage FCW computation. The result is held as a pending update
// and then applied to the phase accumulator.
//
// Optional feature macro: DDS_WRAP_SYNC_EN
//   defined   : a pending update is applied only on a phase_wrap pulse, and
//               only when no newer computation is in flight.
//   undefined : a pending update is applied on the edge after it appears.
//
// Ports
//   sys_clk          in   system clock, all logic on the rising edge
//   sys_rst_n        in   asynchronous active-low reset
//   waveform_counter in   [1:0]  waveform select
//   freq_counter     in   [4:0]  coarse frequency index k
//   freq_counter2    in   [4:0]  fine frequency index f
//   rom_addr         out  [ADDR_W+1:0] {wave_active, acc top ADDR_W bits}
//   phase_wrap       out  registered accumulator carry-out pulse
//   upd_pending      out  computed settings waiting to be applied
//   fcw_active       out  [PHASE_W-1:0] FCW driving the accumulator
//
// Qualifier rule: s1_valid_q marks that stage-1 registers hold a fresh
// result for stage 2 to consume on the next edge. upd_pending_q marks that
// fcw_next_q/wave_next_q hold a result not yet applied. There is no
// back-pressure: a newer result overwrites an older one.
// ---------------------------------------------------------------------------
module dds_phase_ctrl #(
  parameter int PHASE_W  = 32,
  parameter int ADDR_W   = 12,
  parameter int BASE_FCW = 10737,
  parameter int FINE_FCW = 86
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [1:0]         waveform_counter,
  input  logic [4:0]         freq_counter,
  input  logic [4:0]         freq_counter2,
  output logic [ADDR_W+1:0]  rom_addr,
  output logic               phase_wrap,
  output logic               upd_pending,
  output logic [PHASE_W-1:0] fcw_active
);

  localparam logic [PHASE_W-1:0] BASE_X4  = PHASE_W'(BASE_FCW * 4);
  localparam logic [PHASE_W-1:0] BASE_X5  = PHASE_W'(BASE_FCW * 5);
  localparam logic [PHASE_W-1:0] BASE_X6  = PHASE_W'(BASE_FCW * 6);
  localparam logic [PHASE_W-1:0] BASE_X7  = PHASE_W'(BASE_FCW * 7);
  localparam logic [PHASE_W-1:0] FINE_STEP = PHASE_W'(FINE_FCW);

  // Settings word layout: {wave[11:10], k[9:5], f[4:0]}
  logic [11:0] set_in;
  assign set_in = {waveform_counter, freq_counter, freq_counter2};

  // Change detection
  logic [11:0]        in_q, in_d;
  logic [11:0]        prev_q, prev_d;
  logic               start_q, start_d;
  // Stage 1
  logic               s1_valid_q, s1_valid_d;
  logic [PHASE_W-1:0] s1_coarse_q, s1_coarse_d;
  logic [PHASE_W-1:0] s1_fine_q, s1_fine_d;
  logic [1:0]         s1_wave_q, s1_wave_d;
  // Stage 2 / pending update
  logic [PHASE_W-1:0] fcw_next_q, fcw_next_d;
  logic [1:0]         wave_next_q, wave_next_d;
  logic               upd_pending_q, upd_pending_d;
  // Accumulator and active settings
  logic [PHASE_W-1:0] acc_q, acc_d;
  logic               phase_wrap_q, phase_wrap_d;
  logic [PHASE_W-1:0] fcw_active_q, fcw_active_d;
  logic [1:0]         wave_active_q, wave_active_d;
  logic [ADDR_W+1:0]  rom_addr_q, rom_addr_d;

  logic [PHASE_W-1:0] base_mult;
  logic               apply;

  // Base multiplier M[k[1:0]] = {4,5,6,7}, taken from the sample being computed
  always_comb begin
    base_mult = BASE_X4;
    case (prev_q[6:5])
      2'd0: base_mult = BASE_X4;
      2'd1: base_mult = BASE_X5;
      2'd2: base_mult = BASE_X6;
      2'd3: base_mult = BASE_X7;
      default: base_mult = BASE_X4;
    endcase
  end

`ifdef DDS_WRAP_SYNC_EN
  logic busy;
  // A newer sample anywhere in the compute path makes fcw_next_q stale.
  // Holding the apply off until that result lands keeps intermediate FCWs
  // off the accumulator.
  assign busy  = (in_q != prev_q) | start_q | s1_valid_q;
  assign apply = phase_wrap_q & upd_pending_q & ~busy;
`else
  assign apply = upd_pending_q;
`endif

  always_comb begin
    // Change detection: in_q is this edge's sample, prev_q the one before it
    in_d    = set_in;
    prev_d  = in_q;
    start_d = (in_q != prev_q);

    // Stage 1: prev_q holds the sample that raised start_q
    s1_valid_d  = start_q;
    s1_coarse_d = s1_coarse_q;
    s1_fine_d   = s1_fine_q;
    s1_wave_d   = s1_wave_q;
    if (start_q) begin
      s1_coarse_d = base_mult << prev_q[9:7];
      s1_fine_d   = FINE_STEP * {{(PHASE_W-5){1'b0}}, prev_q[4:0]};
      s1_wave_d   = prev_q[11:10];
    end

    // Stage 2: a new result always wins over an unapplied older one
    fcw_next_d    = fcw_next_q;
    wave_next_d   = wave_next_q;
    upd_pending_d = upd_pending_q;
    if (s1_valid_q) begin
      fcw_next_d    = s1_coarse_q + s1_fine_q;
      wave_next_d   = s1_wave_q;
      upd_pending_d = 1'b1;
    end else if (apply) begin
      upd_pending_d = 1'b0;
    end

    // Accumulator: the carry out of the add becomes next cycle's wrap pulse
    {phase_wrap_d, acc_d} = {1'b0, acc_q} + {1'b0, fcw_active_q};

    fcw_active_d  = fcw_active_q;
    wave_active_d = wave_active_q;
    if (apply) begin
      fcw_active_d  = fcw_next_q;
      wave_active_d = wave_next_q;
    end

    rom_addr_d = {wave_active_q, acc_q[PHASE_W-1 -: ADDR_W]};
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      in_q          <= '0;
      prev_q        <= '0;
      start_q       <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_coarse_q   <= '0;
      s1_fine_q     <= '0;
      s1_wave_q     <= '0;
      fcw_next_q    <= '0;
      wave_next_q   <= '0;
      upd_pending_q <= 1'b0;
      acc_q         <= '0;
      phase_wrap_q  <= 1'b0;
      fcw_active_q  <= BASE_X4;
      wave_active_q <= '0;
      rom_addr_q    <= '0;
    end else begin
      in_q          <= in_d;
      prev_q        <= prev_d;
      start_q       <= start_d;
      s1_valid_q    <= s1_valid_d;
      s1_coarse_q   <= s1_coarse_d;
      s1_fine_q     <= s1_fine_d;
      s1_wave_q     <= s1_wave_d;
      fcw_next_q    <= fcw_next_d;
      wave_next_q   <= wave_next_d;
      upd_pending_q <= upd_pending_d;
      acc_q         <= acc_d;
      phase_wrap_q  <= phase_wrap_d;
      fcw_active_q  <= fcw_active_d;
      wave_active_q <= wave_active_d;
      rom_addr_q    <= rom_addr_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign phase_wrap  = phase_wrap_q;
  assign upd_pending = upd_pending_q;
  assign fcw_active  = fcw_active_q;

endmodule

// File: tb/tb_dds_phase_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dds_phase_ctrl
//
// Bench for dds_phase_ctrl. The accumulator is narrowed to 24 bits so that
// phase wraps arrive within a few hundred cycles. A history-based reference
// model predicts every output on every cycle. Literal checks pin the FCW
// arithmetic and the reset values.
// ---------------------------------------------------------------------------
module tb_dds_phase_ctrl;

  localparam int PW = 24;
  localparam int AW = 12;

  logic           sys_clk = 1'b0;
  logic           sys_rst_n;
  logic [1:0]     waveform_counter;
  logic [4:0]     freq_counter;
  logic [4:0]     freq_counter2;
  logic [AW+1:0]  rom_addr;
  logic           phase_wrap;
  logic           upd_pending;
  logic [PW-1:0]  fcw_active;

  dds_phase_ctrl #(.PHASE_W(PW), .ADDR_W(AW), .BASE_FCW(10737), .FINE_FCW(86)) dut (
    .sys_clk          (sys_clk),
    .sys_rst_n        (sys_rst_n),
    .waveform_counter (waveform_counter),
    .freq_counter     (freq_counter),
    .freq_counter2    (freq_counter2),
    .rom_addr         (rom_addr),
    .phase_wrap       (phase_wrap),
    .upd_pending      (upd_pending),
    .fcw_active       (fcw_active)
  );

  // ---------------- clock ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- scoreboard counters ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // FCW straight from the frequency formula, using plain integer arithmetic.
  function automatic logic [PW-1:0] fcw_of(input logic [11:0] s);
    int k;
    int f;
    longint v;
    k = int'(s[9:5]);
    f = int'(s[4:0]);
    v = longint'(10737) * longint'(4 + (k % 4)) * (longint'(1) << (k / 4)) + longint'(f * 86);
    return PW'(v);
  endfunction

  logic [PW-1:0]  m_acc, m_fcw;
  logic [PW:0]    m_sum;
  logic           m_wrap, m_pend, m_apply, m_infl, m_chg;
  logic [1:0]     m_wave;
  logic [AW+1:0]  m_rom;
  logic [11:0]    m_prev, m_cur, m_next;
  // chg_h[i]/val_h[i]: did the setting change i edges ago, and to what value
  logic [3:1]     chg_h;
  logic [11:0]    val_h [1:3];

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_acc  = '0;
      m_fcw  = PW'(4 * 10737);
      m_wrap = 1'b0;
      m_pend = 1'b0;
      m_wave = '0;
      m_rom  = '0;
      m_prev = '0;
      m_next = '0;
      chg_h  = '0;
      for (int i = 1; i <= 3; i++) val_h[i] = '0;
    end else begin
      m_cur  = {waveform_counter, freq_counter, freq_counter2};
      m_chg  = (m_cur != m_prev);
      m_prev = m_cur;
      // Any change sampled in the last three edges has a result still on its way.
      m_infl = |chg_h;
`ifdef DDS_WRAP_SYNC_EN
      m_apply = m_wrap && m_pend && !m_infl;
`else
      m_apply = m_pend;
`endif
      m_rom = {m_wave, m_acc[PW-1 -: AW]};
      m_sum = {1'b0, m_acc} + {1'b0, m_fcw};
      m_wrap = m_sum[PW];
      m_acc  = m_sum[PW-1:0];
      if (m_apply) begin
        m_fcw  = fcw_of(m_next);
        m_wave = m_next[11:10];
      end
      // A change sampled three edges ago becomes the pending result now.
      if (chg_h[3]) begin
        m_pend = 1'b1;
        m_next = val_h[3];
      end else if (m_apply) begin
        m_pend = 1'b0;
      end
      chg_h    = {chg_h[2:1], m_chg};
      val_h[3] = val_h[2];
      val_h[2] = val_h[1];
      val_h[1] = m_cur;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic watch_mid = 1'b0;
  logic mid_seen  = 1'b0;

  always @(negedge sys_clk) begin
    if (sys_rst_n) begin
      chk("rom_addr", 64'(rom_addr), 64'(m_rom));
      chk("phase_wrap", 64'(phase_wrap), 64'(m_wrap));
      chk("upd_pending", 64'(upd_pending), 64'(m_pend));
      chk("fcw_active", 64'(fcw_active), 64'(m_fcw));
      if (watch_mid && (fcw_active == PW'(75159) || fcw_active == PW'(214740)))
        mid_seen = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [1:0] w, input logic [4:0] k, input logic [4:0] f);
    @(negedge sys_clk);
    waveform_counter = w;
    freq_counter     = k;
    freq_counter2    = f;
  endtask

  task automatic wait_fcw(input string name, input logic [PW-1:0] exp, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (fcw_active == exp) break;
      @(negedge sys_clk);
    end
    chk(name, 64'(fcw_active), 64'(exp));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rom"}, 64'(rom_addr), 64'd0);
    chk({tag, "_wrap"}, 64'(phase_wrap), 64'd0);
    chk({tag, "_pend"}, 64'(upd_pending), 64'd0);
    chk({tag, "_fcw"}, 64'(fcw_active), 64'd42948);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    sys_rst_n        = 1'b0;
    waveform_counter = '0;
    freq_counter     = '0;
    freq_counter2    = '0;
    repeat (3) @(negedge sys_clk);
    check_reset_vals("reset");
    #1 sys_rst_n = 1'b1;

    // Inputs held at zero: nothing to compute, default FCW stays.
    repeat (6) @(negedge sys_clk);
    chk("idle_fcw", 64'(fcw_active), 64'd42948);
    chk("idle_pend", 64'(upd_pending), 64'd0);

    // k=5, f=0: the result becomes pending exactly after edge n+3.
    set_in(2'd0, 5'd5, 5'd0);
    repeat (3) @(negedge sys_clk);
    chk("k5_pend_n2", 64'(upd_pending), 64'd0);
    @(negedge sys_clk);
    chk("k5_pend_n3", 64'(upd_pending), 64'd1);
    wait_fcw("k5_fcw", PW'(107370), 2000);

    // k=0, f=10
    set_in(2'd0, 5'd0, 5'd10);
    wait_fcw("k0f10_fcw", PW'(43808), 2000);

    // k=31, f=31: the largest FCW
    set_in(2'd0, 5'd31, 5'd31);
    wait_fcw("max_fcw", PW'(9623018), 2000);

    // k 3 -> 9 -> 12 two cycles apart: only coarse(12) may reach the accumulator.
    watch_mid = 1'b1;
    set_in(2'd0, 5'd3, 5'd0);
    @(negedge sys_clk);
    set_in(2'd0, 5'd9, 5'd0);
    @(negedge sys_clk);
    set_in(2'd0, 5'd12, 5'd0);
    wait_fcw("k12_fcw", PW'(343584), 2000);
    watch_mid = 1'b0;
`ifdef DDS_WRAP_SYNC_EN
    chk("no_intermediate_fcw", 64'(mid_seen), 64'd0);
`endif

    // Waveform 2: the ROM bank bits follow once the update is applied.
    set_in(2'd2, 5'd12, 5'd0);
    for (int i = 0; i < 2000; i++) begin
      if (rom_addr[AW+1:AW] == 2'd2) break;
      @(negedge sys_clk);
    end
    chk("wave2_bank", 64'(rom_addr[AW+1:AW]), 64'd2);

    // k=1
    set_in(2'd2, 5'd1, 5'd0);
`ifdef DDS_WRAP_SYNC_EN
    wait_fcw("k1_fcw", PW'(53685), 2000);
`else
    repeat (4) @(negedge sys_clk);
    chk("k1_before_n4", 64'(fcw_active), 64'd343584);
    @(negedge sys_clk);
    chk("k1_after_n4", 64'(fcw_active), 64'd53685);
`endif

    // Randomized settings with random hold times, plus one reset mid-run
    for (int it = 0; it < 80; it++) begin
      set_in(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      repeat ($urandom_range(0, 40)) @(negedge sys_clk);
      if (it == 40) begin
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b0;
        #1 check_reset_vals("midrst");
        @(negedge sys_clk);
        #1 sys_rst_n = 1'b1;
      end
    end

    repeat (20) @(negedge sys_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
